// File: rtl/segre_pkg.sv
// segre_pkg: shared types and constants for the segre memory subsystem
package segre_pkg;
   localparam int CACHE_LINE_SIZE_BYTES = 16;
   localparam int ADDR_SIZE = 32;
   localparam int MEM_LATENCY_CYCLES = 5;
   typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_id_e;
   typedef struct packed {
      logic rd;
      logic wr;
      logic [ADDR_SIZE-1:0] addr;
      logic [CACHE_LINE_SIZE_BYTES*8-1:0] data;
      cache_id_e cache_id;
   } cache_mem_req_t;
   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} mem_sched_state_e;
   // Queued form of a request: rd is folded away because rd&wr behaves as a write
   typedef struct packed {
      logic we;
      logic [ADDR_SIZE-1:0] addr;
      logic [CACHE_LINE_SIZE_BYTES*8-1:0] data;
      cache_id_e cache_id;
   } mem_sched_entry_t;
endpackage

// File: rtl/segre_req_fifo.sv
// segre_req_fifo: first-word-fall-through request FIFO with occupancy count
module segre_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign rdata = mem[rd_ptr];
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/segre_mem_sched.sv
// segre_mem_sched: queues cache memory requests and serialises them onto one
// memory port with a fixed access latency, returning one response per request
import segre_pkg::*;
module segre_mem_sched #(
   parameter int QUEUE_DEPTH = 4,
   parameter int MEM_LATENCY = MEM_LATENCY_CYCLES,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                               clk_i,
   input  logic                               rsn_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  cache_mem_req_t                     req_i,
   output logic                               mem_en_o,
   output logic                               mem_we_o,
   output logic [ADDR_WIDTH-1:0]              mem_addr_o,
   output logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wdata_o,
   input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_rdata_i,
   output logic                               rsp_valid_o,
   output cache_id_e                          rsp_cache_id_o,
   output logic [CACHE_LINE_SIZE_BYTES*8-1:0] rsp_line_o
);
   localparam int CNTW = $clog2(MEM_LATENCY + 1);
   localparam int QCW = $clog2(QUEUE_DEPTH + 1);
   mem_sched_state_e state, state_nxt;
   logic [CNTW-1:0] cnt;
   mem_sched_entry_t cur, head, in_entry;
   logic push, pop, full, empty;
   logic [QCW-1:0] count;
   // Requests with neither rd nor wr complete the handshake but are never queued
   assign push = req_valid_i && !full && (req_i.rd || req_i.wr);
   assign pop = (state == IDLE || state == RESPOND) && !empty;
   assign req_ready_o = !full;
   assign in_entry = '{we: req_i.wr, addr: req_i.addr, data: req_i.data, cache_id: req_i.cache_id};
   segre_req_fifo #(.WIDTH($bits(mem_sched_entry_t)), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk_i (clk_i),
      .rsn_i (rsn_i),
      .push  (push),
      .wdata (in_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state <= IDLE;
         cnt <= '0;
         cur <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            cur <= head;
            cnt <= CNTW'(MEM_LATENCY - 1);
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CNTW'(1);
         end
      end
   end
   always_comb begin
      state_nxt = pop ? ACCESS :
                  (state == ACCESS && cnt == '0) ? RESPOND :
                  (state == RESPOND) ? IDLE : state;
   end
   // Read data arrives the cycle after mem_en_o, which is exactly the RESPOND cycle
   always_comb begin
      mem_en_o = state == ACCESS && cnt == '0;
      mem_we_o = mem_en_o && cur.we;
      mem_addr_o = mem_en_o ? ADDR_WIDTH'(cur.addr) : '0;
      mem_wdata_o = mem_en_o ? cur.data : '0;
      rsp_valid_o = state == RESPOND;
      rsp_cache_id_o = rsp_valid_o ? cur.cache_id : ICACHE;
      rsp_line_o = !rsp_valid_o ? '0 : cur.we ? cur.data : mem_rdata_i;
   end
   a_count_bound: assert property (@(posedge clk_i) disable iff (!rsn_i) count <= QCW'(QUEUE_DEPTH));
endmodule

// File: tb/tb_segre_mem_sched.sv
// tb_segre_mem_sched: randomized bench against a cycle-timed transaction model
module tb_segre_mem_sched;
   import segre_pkg::*;
   localparam int L = 5;
   localparam int QD = 4;
   localparam int LW = CACHE_LINE_SIZE_BYTES * 8;
   typedef logic [LW-1:0] line_t;
   typedef struct {
      int acc;
      int pop;
      int rsp;
      logic we;
      logic [31:0] addr;
      line_t data;
      cache_id_e id;
      line_t exp;
   } exp_t;
   logic clk = 1'b0;
   logic rsn = 1'b0;
   logic req_valid = 1'b0;
   cache_mem_req_t req = '0;
   logic req_ready, mem_en, mem_we, rsp_valid;
   logic [31:0] mem_addr;
   line_t mem_wdata, rsp_line;
   line_t mem_rdata = '0;
   cache_id_e rsp_id;
   line_t tb_mem [16];
   line_t ref_mem [16];
   exp_t q[$];
   int last_rsp = -100;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   segre_mem_sched #(.QUEUE_DEPTH(QD), .MEM_LATENCY(L), .ADDR_WIDTH(32)) dut (
      .clk_i          (clk),
      .rsn_i          (rsn),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_i          (req),
      .mem_en_o       (mem_en),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rdata_i    (mem_rdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_cache_id_o (rsp_id),
      .rsp_line_o     (rsp_line)
   );
   // Synchronous-read memory sitting on the DUT's port
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr[9:6]] <= mem_wdata;
         else mem_rdata <= tb_mem[mem_addr[9:6]];
      end
   end
   task automatic check(input string tag, input line_t got, input line_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask
   // Model: request accepted at edge e is popped at max(e+1, prev_rsp+1), mem access
   // L-1 cycles later, response one cycle after that; memory effects applied in order.
   task automatic check_cycle();
      int occ;
      int ri;
      bit en_hit;
      occ = 0;
      ri = -1;
      en_hit = 0;
      foreach (q[i]) begin
         if (q[i].rsp - 1 == cyc) begin
            en_hit = 1;
            check("mem_en", LW'(mem_en), LW'(1));
            check("mem_we", LW'(mem_we), LW'(q[i].we));
            check("mem_addr", LW'(mem_addr), LW'(q[i].addr));
            if (q[i].we) begin
               check("mem_wdata", mem_wdata, q[i].data);
               ref_mem[q[i].addr[9:6]] = q[i].data;
            end
            q[i].exp = ref_mem[q[i].addr[9:6]];
         end
         if (q[i].rsp == cyc) begin
            ri = i;
            check("rsp_valid", LW'(rsp_valid), LW'(1));
            check("rsp_id", LW'(rsp_id), LW'(q[i].id));
            check("rsp_line", rsp_line, q[i].exp);
         end
         if (q[i].acc <= cyc && q[i].pop > cyc) occ++;
      end
      if (!en_hit) begin
         check("mem_en_idle", LW'(mem_en), '0);
         check("mem_we_idle", LW'(mem_we), '0);
         check("mem_addr_idle", LW'(mem_addr), '0);
         check("mem_wdata_idle", mem_wdata, '0);
      end
      if (ri < 0) begin
         check("rsp_valid_idle", LW'(rsp_valid), '0);
         check("rsp_id_idle", LW'(rsp_id), '0);
         check("rsp_line_idle", rsp_line, '0);
      end else begin
         q.delete(ri);
      end
      check("req_ready", LW'(req_ready), LW'(occ < QD));
   endtask
   task automatic step(input logic v, input cache_mem_req_t r, input logic rs, output bit acc);
      exp_t e;
      check_cycle();
      rsn = rs;
      req_valid = v && rs;
      req = r;
      acc = 0;
      if (!rs) begin
         q.delete();
         last_rsp = -100;
      end else if (v && req_ready) begin
         acc = 1;
         if (r.rd || r.wr) begin
            e.acc = cyc + 1;
            e.pop = (e.acc + 1 > last_rsp + 1) ? e.acc + 1 : last_rsp + 1;
            e.rsp = e.pop + L;
            e.we = r.wr;
            e.addr = r.addr;
            e.data = r.data;
            e.id = r.cache_id;
            e.exp = '0;
            last_rsp = e.rsp;
            q.push_back(e);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
   endtask
   function automatic cache_mem_req_t mk(input logic rd, input logic wr, input int idx, input line_t d, input cache_id_e id);
      mk.rd = rd;
      mk.wr = wr;
      mk.addr = 32'(idx) << 6;
      mk.data = d;
      mk.cache_id = id;
   endfunction
   initial begin
      bit a;
      int k;
      logic rs, v;
      int rw;
      for (int i = 0; i < 16; i++) begin
         tb_mem[i] <= {4{32'hC0DE_0000 | 32'(i)}};
         ref_mem[i] = {4{32'hC0DE_0000 | 32'(i)}};
      end
      tb_mem[1] <= {16{8'hA5}};
      ref_mem[1] = {16{8'hA5}};
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      step(1'b0, '0, 1'b0, a);
      idle(2);
      step(1'b1, mk(1'b1, 1'b0, 1, '0, DCACHE), 1'b1, a);
      idle(10);
      step(1'b1, mk(1'b0, 1'b1, 2, {8{16'h1234}}, ICACHE), 1'b1, a);
      step(1'b1, mk(1'b1, 1'b0, 2, '0, DCACHE), 1'b1, a);
      idle(16);
      k = 0;
      for (int t = 0; t < 200 && k < 6; t++) begin
         step(1'b1, mk(1'b1, 1'b0, k + 3, '0, k[0] ? DCACHE : ICACHE), 1'b1, a);
         if (a) k++;
      end
      check("six_accepted", LW'(k), LW'(6));
      idle(40);
      step(1'b1, mk(1'b1, 1'b1, 4, {4{32'hFEED_BEEF}}, DCACHE), 1'b1, a);
      idle(3);
      step(1'b0, '0, 1'b0, a);
      idle(10);
      step(1'b1, mk(1'b0, 1'b0, 5, '1, ICACHE), 1'b1, a);
      idle(10);
      for (int t = 0; t < 800; t++) begin
         rs = $urandom_range(0, 199) != 0;
         v = $urandom_range(0, 9) < 6;
         rw = $urandom_range(0, 3);
         step(v, mk(rw[0], rw[1], $urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom},
                    cache_id_e'($urandom_range(0, 1))), rs, a);
      end
      idle(40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
